// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered fixed/round-robin priority encoder with valid/ready output
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        N-bit level request vector
//   out_ready  consumer accepts the current grant
//   out_valid  out_idx / out_onehot hold a valid grant
//   out_idx    binary index of the granted request
//   out_onehot one-hot form of the grant, zero when not valid

module prio_encoder_rr #(
    parameter int N           = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int IDX_W       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot
);

    localparam logic [IDX_W-1:0] TOP   = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N);

    logic [IDX_W-1:0] ptr;
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W:0]   pos;
    logic [N-1:0]     win_onehot;
    logic             load;

    // Walk downward from ptr, wrapping at N (not 2^IDX_W) so a
    // non-power-of-2 N never visits an index outside 0..N-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            if ({1'b0, ptr} >= (IDX_W + 1)'(k)) begin
                pos = {1'b0, ptr} - (IDX_W + 1)'(k);
            end else begin
                pos = {1'b0, ptr} + N_EXT - (IDX_W + 1)'(k);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        if (found) begin
            win_onehot = N'(1) << win;
        end
    end

    // The output stage refills whenever it is empty or being drained.
    assign load = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            ptr        <= TOP;
        end else if (load) begin
            if (found) begin
                out_valid  <= 1'b1;
                out_idx    <= win;
                out_onehot <= win_onehot;
                // The winner drops to lowest priority: search restarts just below it.
                if (ROUND_ROBIN != 0) begin
                    ptr <= (win == '0) ? TOP : win - IDX_W'(1);
                end
            end else begin
                out_valid  <= 1'b0;
                out_idx    <= '0;
                out_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - scoreboard bench for prio_encoder_rr over four parameter sets

module tb_prio_encoder_rr;

    localparam int NI = 4;
    localparam int NV[NI] = '{8, 8, 5, 4};
    localparam int RRV[NI] = '{0, 1, 1, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] req [NI];
    logic       rdy [NI];
    logic       vld [NI];
    logic [7:0] idx [NI];
    logic [7:0] oh  [NI];

    logic [2:0] idx0, idx1, idx2;
    logic [1:0] idx3;
    logic [7:0] oh0, oh1;
    logic [4:0] oh2;
    logic [3:0] oh3;
    logic       v0, v1, v2, v3;

    prio_encoder_rr #(.N(8), .ROUND_ROBIN(0)) u_fix8 (
        .clk(clk), .rst(rst), .req(req[0]), .out_ready(rdy[0]),
        .out_valid(v0), .out_idx(idx0), .out_onehot(oh0));
    prio_encoder_rr #(.N(8), .ROUND_ROBIN(1)) u_rr8 (
        .clk(clk), .rst(rst), .req(req[1]), .out_ready(rdy[1]),
        .out_valid(v1), .out_idx(idx1), .out_onehot(oh1));
    prio_encoder_rr #(.N(5), .ROUND_ROBIN(1)) u_rr5 (
        .clk(clk), .rst(rst), .req(req[2][4:0]), .out_ready(rdy[2]),
        .out_valid(v2), .out_idx(idx2), .out_onehot(oh2));
    prio_encoder_rr #(.N(4), .ROUND_ROBIN(0)) u_fix4 (
        .clk(clk), .rst(rst), .req(req[3][3:0]), .out_ready(rdy[3]),
        .out_valid(v3), .out_idx(idx3), .out_onehot(oh3));

    always_comb begin
        vld[0] = v0;  vld[1] = v1;  vld[2] = v2;  vld[3] = v3;
        idx[0] = 8'(idx0); idx[1] = 8'(idx1); idx[2] = 8'(idx2); idx[3] = 8'(idx3);
        oh[0]  = oh0; oh[1] = oh1; oh[2] = 8'(oh2); oh[3] = 8'(oh3);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    endtask

    // Reference model: priority order is ptr, ptr-1, ... wrapping mod n.
    int m_ptr   [NI];
    bit m_valid [NI];
    int fifo    [NI][16];
    int wp [NI], rp [NI], cnt [NI];

    function automatic int ref_winner(input int n, input int ptr, input logic [7:0] r);
        for (int step = 0; step < n; step++) begin
            int cand;
            cand = (ptr - step + n) % n;
            if (r[cand]) return cand;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_ptr[i] = NV[i] - 1;
            m_valid[i] = 1'b0;
            wp[i] = 0; rp[i] = 0; cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (!m_valid[i] || rdy[i]) begin
                int g;
                g = ref_winner(NV[i], m_ptr[i], req[i]);
                if (g < 0) begin
                    m_valid[i] = 1'b0;
                end else begin
                    fifo[i][wp[i]] = g;
                    wp[i] = (wp[i] + 1) % 16;
                    cnt[i]++;
                    m_valid[i] = 1'b1;
                    if (RRV[i] != 0) m_ptr[i] = (g + NV[i] - 1) % NV[i];
                end
            end
        end
    endtask

    // Monitor: compares held grants against the scoreboard head, pops on transfer.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                chk("valid", i, vld[i], m_valid[i]);
                if (vld[i]) begin
                    chk("sb_depth", i, cnt[i], 1);
                    if (cnt[i] > 0) begin
                        e = fifo[i][rp[i]];
                        chk("sb_idx", i, idx[i], e);
                        chk("sb_onehot", i, oh[i], 1 << e);
                        if (rdy[i]) begin
                            rp[i] = (rp[i] + 1) % 16;
                            cnt[i]--;
                        end
                    end
                end else begin
                    chk("idle_idx", i, idx[i], 0);
                    chk("idle_onehot", i, oh[i], 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NI; i++) begin
            req[i] = '0;
            rdy[i] = 1'b0;
        end
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int exp_rr8 [9];
        int exp_rr5 [6];
        logic [3:0] v42 [5];
        int exp42 [5];
        exp_rr8 = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        exp_rr5 = '{4, 3, 2, 1, 0, 4};
        v42   = '{4'b0001, 4'b0011, 4'b0110, 4'b1010, 4'b1111};
        exp42 = '{0, 1, 2, 3, 3};

        model_reset();
        for (int i = 0; i < NI; i++) begin
            req[i] = '0;
            rdy[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", i, vld[i], 0);
            chk("rst_idx", i, idx[i], 0);
            chk("rst_onehot", i, oh[i], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Fixed priority grant and fall of valid on idle request
        req[0] = 8'b0010_1100; rdy[0] = 1'b1;
        step();
        chk("fix_idx", 0, idx[0], 5);
        chk("fix_onehot", 0, oh[0], 8'h20);
        chk("fix_valid", 0, vld[0], 1);
        req[0] = 8'h00;
        step();
        chk("fix_idle", 0, vld[0], 0);

        // Back-pressure holds the grant regardless of req
        req[0] = 8'b0010_1100;
        step();
        rdy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req[0] = (k % 2 == 0) ? 8'h01 : 8'h00;
            step();
            chk("hold_idx", 0, idx[0], 5);
            chk("hold_onehot", 0, oh[0], 8'h20);
            chk("hold_valid", 0, vld[0], 1);
        end
        rdy[0] = 1'b1; req[0] = 8'h01;
        step();
        chk("release_idx", 0, idx[0], 0);

        // Round-robin full sweep with no bubbles
        do_reset();
        req[1] = 8'hFF; rdy[1] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rr_sweep_idx", 1, idx[1], exp_rr8[k]);
            chk("rr_sweep_valid", 1, vld[1], 1);
        end

        // Fairness: round-robin alternates, fixed always picks the MSB
        do_reset();
        req[0] = 8'h81; rdy[0] = 1'b1;
        req[1] = 8'h81; rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_fair", 1, idx[1], (k % 2 == 0) ? 7 : 0);
            chk("fix_fair", 0, idx[0], 7);
        end

        // Non-power-of-2 wrap and the 4:2 vectors
        do_reset();
        req[2] = 8'h1F; rdy[2] = 1'b1; rdy[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req[3] = 8'(v42[k % 5]);
            step();
            chk("rr5_idx", 2, idx[2], exp_rr5[k]);
            if (k < 5) chk("enc42_idx", 3, idx[3], exp42[k]);
        end

        // Asynchronous reset mid-operation, then first grant uses ptr = N-1
        do_reset();
        req[0] = 8'hFF; req[1] = 8'hFF; rdy[0] = 1'b1; rdy[1] = 1'b1;
        step();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_valid", i, vld[i], 0);
            chk("async_idx", i, idx[i], 0);
            chk("async_onehot", i, oh[i], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("post_rst_idx", 0, idx[0], 7);
        chk("post_rst_idx", 1, idx[1], 7);

        // Randomised traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                logic [7:0] mask;
                mask = 8'((1 << NV[i]) - 1);
                req[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : (8'($urandom) & mask);
                rdy[i] = ($urandom_range(0, 9) < 7);
            end
            step();
        end

        // Drain: every pushed grant must have been transferred
        for (int i = 0; i < NI; i++) begin
            req[i] = '0;
            rdy[i] = 1'b1;
        end
        repeat (3) step();
        @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("drain_depth", i, cnt[i], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
